// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared types and helpers for the pushbutton front-end.
package button_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        LONG_HELD,
        DEB_RELEASE
    } btn_state_e;

    localparam int PRESS_COUNT_W = 8;

    function automatic int ms_to_cycles(input int freq_hz, input int ms);
        return (freq_hz / 1000) * ms;
    endfunction

    // Never below 1 bit so a terminal value of 1 still yields a legal vector.
    function automatic int cnt_width(input int terminal);
        return (terminal > 1) ? $clog2(terminal) : 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for one asynchronous input.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounce and classify a raw pushbutton into press/release/long strobes.
// Optional auto-repeat of press strobes while long-held: define BUTTON_AUTO_REPEAT_EN.
module button_conditioner
    import button_pkg::*;
#(
    parameter int CLK_FREQ_HZ      = 50_000_000,
    parameter int DEBOUNCE_TIME_MS = 10,
    parameter int LONG_PRESS_MS    = 1000,
    parameter bit ACTIVE_LOW_BTN   = 1'b0,
    parameter int REPEAT_MS        = 200
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     button_in,
    output logic                     btn_level,
    output logic                     push_led,
    output logic                     press_pulse,
    output logic                     release_pulse,
    output logic                     long_press_pulse,
    output logic [PRESS_COUNT_W-1:0] press_count
);

    localparam int DEB_CYCLES  = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_TIME_MS);
    localparam int LONG_CYCLES = ms_to_cycles(CLK_FREQ_HZ, LONG_PRESS_MS);
    localparam int DEB_W       = cnt_width(DEB_CYCLES);
    localparam int LONG_W      = cnt_width(LONG_CYCLES);

    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

    logic btn_raw;
    logic sync;

    assign btn_raw = ACTIVE_LOW_BTN ? ~button_in : button_in;

    sync_2ff #(
        .RESET_VALUE(1'b0)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (sync)
    );

    btn_state_e               state_q, state_d;
    logic [DEB_W-1:0]         deb_cnt_q, deb_cnt_d;
    logic [LONG_W-1:0]        hold_cnt_q, hold_cnt_d;
    logic                     ret_long_q, ret_long_d;
    logic                     level_q, level_d;
    logic                     press_q, press_d;
    logic                     release_q, release_d;
    logic                     long_q, long_d;
    logic [PRESS_COUNT_W-1:0] count_q, count_d;

`ifdef BUTTON_AUTO_REPEAT_EN
    localparam int REPEAT_CYCLES = ms_to_cycles(CLK_FREQ_HZ, REPEAT_MS);
    localparam int REP_W         = cnt_width(REPEAT_CYCLES);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_q <= '0;
        end else begin
            rep_cnt_q <= rep_cnt_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            deb_cnt_q  <= '0;
            hold_cnt_q <= '0;
            ret_long_q <= 1'b0;
            level_q    <= 1'b0;
            press_q    <= 1'b0;
            release_q  <= 1'b0;
            long_q     <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            deb_cnt_q  <= deb_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            ret_long_q <= ret_long_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            long_q     <= long_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        deb_cnt_d  = deb_cnt_q;
        hold_cnt_d = hold_cnt_q;
        ret_long_d = ret_long_q;
        level_d    = level_q;
        press_d    = 1'b0;
        release_d  = 1'b0;
        long_d     = 1'b0;
        count_d    = count_q;
`ifdef BUTTON_AUTO_REPEAT_EN
        rep_cnt_d  = rep_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (sync) begin
                    state_d   = DEB_PRESS;
                    deb_cnt_d = '0;
                end
            end
            DEB_PRESS: begin
                if (!sync) begin
                    state_d = IDLE;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d    = PRESSED;
                    press_d    = 1'b1;
                    level_d    = 1'b1;
                    count_d    = count_q + PRESS_COUNT_W'(1);
                    hold_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            PRESSED: begin
                // A falling sample takes precedence over reaching the long-press threshold.
                if (!sync) begin
                    state_d    = DEB_RELEASE;
                    deb_cnt_d  = '0;
                    ret_long_d = 1'b0;
                end else if (hold_cnt_q == LONG_LAST) begin
                    state_d = LONG_HELD;
                    long_d  = 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
                    rep_cnt_d = '0;
`endif
                end else begin
                    hold_cnt_d = hold_cnt_q + LONG_W'(1);
                end
            end
            LONG_HELD: begin
                if (!sync) begin
                    state_d    = DEB_RELEASE;
                    deb_cnt_d  = '0;
                    ret_long_d = 1'b1;
                end
`ifdef BUTTON_AUTO_REPEAT_EN
                else if (rep_cnt_q == REP_LAST) begin
                    rep_cnt_d = '0;
                    press_d   = 1'b1;
                    count_d   = count_q + PRESS_COUNT_W'(1);
                end else begin
                    rep_cnt_d = rep_cnt_q + REP_W'(1);
                end
`endif
            end
            DEB_RELEASE: begin
                // A bounce back to pressed resumes the hold where it was, silently.
                if (sync) begin
                    state_d = ret_long_q ? LONG_HELD : PRESSED;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DEB_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign btn_level        = level_q;
    assign push_led         = level_q;
    assign press_pulse      = press_q;
    assign release_pulse    = release_q;
    assign long_press_pulse = long_q;
    assign press_count      = count_q;

endmodule
